// File: rtl/time_manager_ctrl.sv
// -----------------------------------------------------------------------------
// time_manager_ctrl
//
// Global timestep selection and emulation-time accumulation for the emulator
// clock domain. Each cycle the smallest valid, non-negative dt request is
// chosen, capped by dt_max. The choice is clamped so emu_time never steps past
// stop_time when stop-at-time is enabled. Run / pause / single-step control is
// a three-state FSM (IDLE, RUN, HALT). emu_time saturates at the largest
// positive value and sets a sticky overflow flag.
//
// Parameters
//   n          number of dt request channels (>= 1)
//   width      signed width of dt_req, dt_max and emu_dt
//   time_width signed width of emu_time and stop_time (>= width)
//   cnt_width  width of step_count
//   idx_width  width of emu_dt_idx
//
// Ports
//   emu_clk     in   emulator clock, all state changes on the rising edge
//   emu_rst     in   asynchronous active-high reset
//   dt_req      in   n x width signed per-channel requested timestep
//   dt_valid    in   n per-channel request enable
//   dt_max      in   width signed upper bound on the timestep
//   ctrl_run    in   level, continuous advance request
//   ctrl_step   in   single-cycle advance request, honoured in IDLE
//   stop_en     in   enables stop-at-time
//   stop_time   in   time_width signed target halt time
//   emu_dt      out  dt applied this cycle, 0 when not advancing (combinational)
//   emu_dt_idx  out  channel that set the minimum dt (combinational)
//   emu_dt_lim  out  dt set by dt_max, stop clamp or no valid channel
//   emu_time    out  accumulated emulation time
//   state       out  0=IDLE, 1=RUN, 2=HALT
//   step_count  out  number of advancing cycles, saturating
//   time_ovf    out  sticky, emu_time has saturated
// -----------------------------------------------------------------------------
module time_manager_ctrl #(
    parameter int n          = 4,
    parameter int width      = 32,
    parameter int time_width = 48,
    parameter int cnt_width  = 32,
    parameter int idx_width  = (n > 1) ? $clog2(n) : 1
) (
    input  logic                         emu_clk,
    input  logic                         emu_rst,
    input  logic signed [width-1:0]      dt_req [n],
    input  logic        [n-1:0]          dt_valid,
    input  logic signed [width-1:0]      dt_max,
    input  logic                         ctrl_run,
    input  logic                         ctrl_step,
    input  logic                         stop_en,
    input  logic signed [time_width-1:0] stop_time,
    output logic signed [width-1:0]      emu_dt,
    output logic        [idx_width-1:0]  emu_dt_idx,
    output logic                         emu_dt_lim,
    output logic signed [time_width-1:0] emu_time,
    output logic        [1:0]            state,
    output logic        [cnt_width-1:0]  step_count,
    output logic                         time_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Time arithmetic is carried one bit wider so overflow past the positive
    // limit is visible before saturation.
    localparam int SW = time_width + 1;
    localparam logic signed [SW-1:0] TIME_MAX = SW'({1'b0, {(time_width-1){1'b1}}});

    // Negative requests and bounds mean "no time", never a step backwards.
    function automatic logic signed [width-1:0] clip_neg(input logic signed [width-1:0] v);
        return v[width-1] ? '0 : v;
    endfunction

    function automatic logic signed [SW-1:0] sext_dt(input logic signed [width-1:0] v);
        return {{(SW-width){v[width-1]}}, v};
    endfunction

    function automatic logic signed [SW-1:0] sext_time(input logic signed [time_width-1:0] v);
        return {v[time_width-1], v};
    endfunction

    function automatic logic signed [time_width-1:0] sat_time(input logic signed [SW-1:0] s);
        if (s > TIME_MAX) begin
            return TIME_MAX[time_width-1:0];
        end
        return time_width'(s);
    endfunction

    state_t                        state_q, state_d;
    logic signed [time_width-1:0]  time_q, time_d;
    logic        [cnt_width-1:0]   cnt_q, cnt_d;
    logic                          ovf_q, ovf_d;

    logic signed [width-1:0]       max_c;
    logic signed [width-1:0]       best_c;
    logic signed [width-1:0]       dt_sel;
    logic        [idx_width-1:0]   best_idx;
    logic                          any_vld;
    logic                          lim_sel;

    logic                          advance;
    logic                          clamp;
    logic signed [SW-1:0]          reach;
    logic signed [SW-1:0]          gap;
    logic signed [SW-1:0]          sum;

    // Minimum search: strict less-than keeps the lowest index on ties.
    always_comb begin
        max_c    = clip_neg(dt_max);
        best_c   = '0;
        best_idx = '0;
        any_vld  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (dt_valid[i]) begin
                if (!any_vld || (clip_neg(dt_req[i]) < best_c)) begin
                    best_c   = clip_neg(dt_req[i]);
                    best_idx = idx_width'(i);
                end
                any_vld = 1'b1;
            end
        end

        if (!any_vld) begin
            dt_sel  = max_c;
            lim_sel = 1'b1;
        end else if (max_c < best_c) begin
            dt_sel  = max_c;
            lim_sel = 1'b1;
        end else begin
            dt_sel  = best_c;
            lim_sel = 1'b0;
        end
    end

    // Advance decision and stop clamp. The clamped step is at most dt_sel,
    // so the truncation of gap back to width bits is lossless.
    always_comb begin
        advance = (state_q == ST_RUN) || ((state_q == ST_IDLE) && ctrl_step);
        reach   = sext_time(time_q) + sext_dt(dt_sel);
        gap     = sext_time(stop_time) - sext_time(time_q);
        clamp   = advance && stop_en && (reach >= sext_time(stop_time));

        emu_dt = '0;
        if (clamp) begin
            emu_dt = gap[SW-1] ? '0 : width'(gap);
        end else if (advance) begin
            emu_dt = dt_sel;
        end
        emu_dt_lim = lim_sel | clamp;
        emu_dt_idx = best_idx;
    end

    // Next-state: time accumulation, step counter, FSM.
    always_comb begin
        sum    = sext_time(time_q) + sext_dt(emu_dt);
        time_d = sat_time(sum);
        ovf_d  = ovf_q | (sum > TIME_MAX);

        cnt_d = cnt_q;
        if (advance && !(&cnt_q)) begin
            cnt_d = cnt_q + cnt_width'(1);
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A clamping single step wins over a run request.
                if (clamp) begin
                    state_d = ST_HALT;
                end else if (ctrl_run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clamp) begin
                    state_d = ST_HALT;
                end else if (!ctrl_run) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (!ctrl_run && !ctrl_step) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign emu_time   = time_q;
    assign state      = state_q;
    assign step_count = cnt_q;
    assign time_ovf   = ovf_q;

endmodule
